// File: rtl/mdu_defs.sv
// Shared definitions for the MDU sequencer: op codes, FSM states, default latencies.
package mdu_defs;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8
    } md_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide on the latched operands.
// res is {hi, lo}: {product_hi, product_lo} for multiplies, {remainder, quotient} for divides.
module mdu_arith
    import mdu_defs::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] res,
    output logic        div_zero
);

    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;

    // Signed divide is done on magnitudes so 0x80000000 / -1 wraps to 0x80000000 without overflow.
    assign a_neg = a[31];
    assign b_neg = b[31];
    assign a_mag = a_neg ? (32'd0 - a) : a;
    assign b_mag = b_neg ? (32'd0 - b) : b;
    assign q_mag = a_mag / b_mag;
    assign r_mag = a_mag % b_mag;

    // Select the result for the latched op.
    always_comb begin
        res      = '0;
        div_zero = 1'b0;
        case (op)
            MD_MULT:  res = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            MD_MULTU: res = {32'd0, a} * {32'd0, b};
            MD_DIV: begin
                div_zero = (b == 32'd0);
                res[31:0]  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
                res[63:32] = a_neg ? (32'd0 - r_mag) : r_mag;
            end
            MD_DIVU: begin
                div_zero = (b == 32'd0);
                res      = {a % b, a / b};
            end
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/mdu_sched.sv
// Multi-cycle multiply/divide sequencer: owns HI/LO and stalls MDU users in D while busy.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | accepting start / MTHI / MTLO
// ST_MUL  | multiply in flight, cnt_q = remaining cycles
// ST_DIV  | divide in flight, cnt_q = remaining cycles
module mdu_sched
    import mdu_defs::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op_E,
    input  logic        start_E,
    input  logic [31:0] rs_E,
    input  logic [31:0] rt_E,
    input  logic        md_use_D,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_rdata,
    output logic        md_stall
);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [63:0] arith_res;
    logic        div_zero;

    mdu_arith u_arith (
        .op       (op_q),
        .a        (a_q),
        .b        (b_q),
        .res      (arith_res),
        .div_zero (div_zero)
    );

    // State, counter, operand latches and HI/LO registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= MD_NONE;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Next state: leave IDLE on start, return on the last busy cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_E) state_d = is_mul_op(md_op_E) ? ST_MUL : ST_DIV;
            ST_MUL,
            ST_DIV:  if (cnt_q == 4'd1) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: latch operands on start, handle MTHI/MTLO, count down and commit.
    always_comb begin
        cnt_d = cnt_q;
        op_d  = op_q;
        a_d   = a_q;
        b_d   = b_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start_E) begin
                    op_d  = md_op_E;
                    a_d   = rs_E;
                    b_d   = rt_E;
                    cnt_d = is_mul_op(md_op_E) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                end else if (md_op_E == MD_MTHI) begin
                    hi_d = rs_E;
                end else if (md_op_E == MD_MTLO) begin
                    lo_d = rs_E;
                end
            end
            ST_MUL,
            ST_DIV: begin
                cnt_d = cnt_q - 4'd1;
                // A zero divisor still burns the full latency but leaves HI/LO alone.
                if (cnt_q == 4'd1 && !div_zero) begin
                    hi_d = arith_res[63:32];
                    lo_d = arith_res[31:0];
                end
            end
            default: cnt_d = '0;
        endcase
    end

    // Outputs: busy flag, hazard stall and MFHI/MFLO read mux.
    always_comb begin
        busy     = (state_q != ST_IDLE);
        md_stall = md_use_D & (start_E | busy);
        hi       = hi_q;
        lo       = lo_q;
        case (md_op_E)
            MD_MFHI: md_rdata = hi_q;
            MD_MFLO: md_rdata = lo_q;
            default: md_rdata = '0;
        endcase
    end

endmodule
